// File: rtl/zcheck_sweep_ctrl.sv
// Sweeps a channel range through the front-end zcheck start/busy/done handshake, one channel at a time.
// Define ZSWEEP_TIMEOUT_EN to add a per-phase timeout with retry and failure bookkeeping.
module zcheck_sweep_ctrl #(
  parameter int CH_W      = 12,
  parameter int TIMEOUT   = 65535,
  parameter int MAX_RETRY = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            sweep_start,
  input  logic            sweep_abort,
  input  logic [CH_W-1:0] ch_first,
  input  logic [CH_W-1:0] ch_last,
  input  logic            dev_busy,
  input  logic            dev_done,
  output logic            dev_start,
  output logic [CH_W-1:0] dev_channel,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic            sweep_aborted,
  output logic            ch_fail,
  output logic [CH_W-1:0] fail_channel,
  output logic [CH_W-1:0] fail_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]      state_q, state_d;
  logic            dev_start_q, dev_start_d;
  logic [CH_W-1:0] chan_q, chan_d;
  logic [CH_W-1:0] last_q, last_d;
  logic            done_flag_q, done_flag_d;
  logic            busy_q, busy_d;
  logic            sweep_done_q, sweep_done_d;
  logic            aborted_q, aborted_d;
  logic            wait_fin;

  // A done pulse arriving in the same cycle that busy is already low completes WAIT at once.
  assign wait_fin = (done_flag_q | dev_done) & ~dev_busy;

`ifdef ZSWEEP_TIMEOUT_EN
  localparam int PH_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [PH_W-1:0] phase_q, phase_d;
  logic [RT_W-1:0] retry_q, retry_d;
  logic            ch_fail_q, ch_fail_d;
  logic [CH_W-1:0] fail_chan_q, fail_chan_d;
  logic [CH_W-1:0] fail_cnt_q, fail_cnt_d;
  logic            timeout_hit;

  // Progress (handshake, completion, abort) always wins over an expiring phase.
  assign timeout_hit = (phase_q == PH_W'(TIMEOUT - 1)) && !sweep_abort &&
                       ((state_q == S_ISSUE && !dev_busy) || (state_q == S_WAIT && !wait_fin));
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through the case infers a latch.
    state_d      = state_q;
    dev_start_d  = dev_start_q;
    chan_d       = chan_q;
    last_d       = last_q;
    done_flag_d  = done_flag_q;
    aborted_d    = aborted_q;
    sweep_done_d = 1'b0;
`ifdef ZSWEEP_TIMEOUT_EN
    phase_d     = '0;
    retry_d     = retry_q;
    ch_fail_d   = 1'b0;
    fail_chan_d = fail_chan_q;
    fail_cnt_d  = fail_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        done_flag_d = 1'b0;
        if (sweep_start) begin
          chan_d    = ch_first;
          last_d    = ch_last;
          aborted_d = 1'b0;
`ifdef ZSWEEP_TIMEOUT_EN
          retry_d    = '0;
          fail_cnt_d = '0;
`endif
          if (ch_first > ch_last) begin
            state_d = S_FINISH;
          end else begin
            state_d     = S_ISSUE;
            dev_start_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (sweep_abort) begin
          dev_start_d = 1'b0;
          state_d     = S_DRAIN;
        end else if (dev_busy) begin
          dev_start_d = 1'b0;
          state_d     = S_WAIT;
        end else begin
          dev_start_d = 1'b1;
`ifdef ZSWEEP_TIMEOUT_EN
          phase_d = phase_q + 1'b1;
`endif
        end
      end
      S_WAIT: begin
        if (sweep_abort) begin
          done_flag_d = 1'b0;
          state_d     = S_DRAIN;
        end else if (wait_fin) begin
          done_flag_d = 1'b0;
          state_d     = S_NEXT;
        end else begin
          done_flag_d = done_flag_q | dev_done;
`ifdef ZSWEEP_TIMEOUT_EN
          phase_d = phase_q + 1'b1;
`endif
        end
      end
      S_NEXT: begin
        if (sweep_abort) begin
          state_d = S_DRAIN;
        end else if (chan_q == last_q) begin
          // Compare before incrementing so an all-ones upper bound never wraps to zero.
          state_d = S_FINISH;
        end else begin
          chan_d      = chan_q + 1'b1;
          state_d     = S_ISSUE;
          dev_start_d = 1'b1;
`ifdef ZSWEEP_TIMEOUT_EN
          retry_d = '0;
`endif
        end
      end
      S_DRAIN: begin
        dev_start_d = 1'b0;
        if (!dev_busy) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end
      end
      S_FINISH: begin
        sweep_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef ZSWEEP_TIMEOUT_EN
    if (timeout_hit) begin
      dev_start_d = 1'b0;
      done_flag_d = 1'b0;
      phase_d     = '0;
      if (retry_q < RT_W'(MAX_RETRY)) begin
        retry_d = retry_q + 1'b1;
        state_d = S_ISSUE;
      end else begin
        ch_fail_d   = 1'b1;
        fail_chan_d = chan_q;
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
        state_d = S_NEXT;
      end
    end
`endif
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      state_q      <= S_IDLE;
      dev_start_q  <= 1'b0;
      chan_q       <= '0;
      last_q       <= '0;
      done_flag_q  <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dev_start_q  <= dev_start_d;
      chan_q       <= chan_d;
      last_q       <= last_d;
      done_flag_q  <= done_flag_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      aborted_q    <= aborted_d;
    end
  end

`ifdef ZSWEEP_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase_q     <= '0;
      retry_q     <= '0;
      ch_fail_q   <= 1'b0;
      fail_chan_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      retry_q     <= retry_d;
      ch_fail_q   <= ch_fail_d;
      fail_chan_q <= fail_chan_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign ch_fail      = ch_fail_q;
  assign fail_channel = fail_chan_q;
  assign fail_count   = fail_cnt_q;
`else
  assign ch_fail      = 1'b0;
  assign fail_channel = '0;
  assign fail_count   = '0;
`endif

  assign dev_start     = dev_start_q;
  assign dev_channel   = chan_q;
  assign sweep_busy    = busy_q;
  assign sweep_done    = sweep_done_q;
  assign sweep_aborted = aborted_q;

endmodule

// File: tb/tb_zcheck_sweep_ctrl.sv
// Scoreboard bench for zcheck_sweep_ctrl: a sweep-level model queues expected issue/fail/done
// events, a responsive front-end model drives busy/done, and a monitor pops and compares events.
module tb_zcheck_sweep_ctrl;
  localparam int CH_W      = 12;
  localparam int TIMEOUT   = 20;
  localparam int MAX_RETRY = 2;
  localparam int CH_MAX    = (1 << CH_W) - 1;

  logic            clk = 1'b0;
  logic            rstn, sweep_start, sweep_abort, dev_busy, dev_done;
  logic [CH_W-1:0] ch_first, ch_last;
  logic            dev_start, sweep_busy, sweep_done, sweep_aborted, ch_fail;
  logic [CH_W-1:0] dev_channel, fail_channel, fail_count;

  zcheck_sweep_ctrl #(.CH_W(CH_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rstn(rstn), .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .ch_first(ch_first), .ch_last(ch_last), .dev_busy(dev_busy), .dev_done(dev_done),
    .dev_start(dev_start), .dev_channel(dev_channel), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .sweep_aborted(sweep_aborted), .ch_fail(ch_fail),
    .fail_channel(fail_channel), .fail_count(fail_count)
  );

  initial forever #5 clk = ~clk;

  typedef enum int {EV_ISSUE, EV_FAIL, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       ch;
    int       cnt;
    bit       ab;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, errors = 0, done_cnt = 0;
  int  dead_ch = -1, abort_ch = -1;
  bit  fixed_timing = 1'b1, dev_rst = 1'b0;
  time start_t, issue_t, done_t, busy_fall_t;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void push(input ev_kind_e k, input int ch, input int cnt, input bit ab);
    ev_t e;
    e.kind = k; e.ch = ch; e.cnt = cnt; e.ab = ab;
    exp_q.push_back(e);
  endfunction

  // Sweep-level model: the ordered list of events one sweep must produce.
  function automatic void build_expect(input int first, input int last);
    int fails = 0;
    if (first > last) begin
      push(EV_DONE, 0, 0, 1'b0);
      return;
    end
    for (int c = first; c <= last; c++) begin
      if (c == abort_ch) begin
        push(EV_ISSUE, c, 0, 1'b0);
        push(EV_DONE, 0, fails, 1'b1);
        return;
      end
      if (c == dead_ch) begin
        for (int r = 0; r <= MAX_RETRY; r++) push(EV_ISSUE, c, 0, 1'b0);
        fails = (fails < CH_MAX) ? fails + 1 : fails;
        push(EV_FAIL, c, fails, 1'b0);
      end else begin
        push(EV_ISSUE, c, 0, 1'b0);
      end
    end
    push(EV_DONE, 0, fails, 1'b0);
  endfunction

  task automatic expect_ev(input ev_kind_e kind, input int ch, input int cnt, input bit ab);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d channel %0d, expected no event", int'(kind), ch);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", int'(kind), int'(e.kind));
    if (kind == e.kind) begin
      if (kind != EV_DONE) check("event_channel", ch, e.ch);
      if (kind != EV_ISSUE) check("fail_count", cnt, e.cnt);
      if (kind == EV_DONE) check("sweep_aborted", ab, e.ab);
    end
  endtask

  // Monitor: samples on the falling edge, turns DUT activity into events.
  initial begin
    logic prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        if (ch_fail) expect_ev(EV_FAIL, int'(fail_channel), int'(fail_count), 1'b0);
        if (dev_start && !prev_start) begin
          if (issue_t == 0) issue_t = $time;
          expect_ev(EV_ISSUE, int'(dev_channel), 0, 1'b0);
        end
        if (sweep_done) begin
          done_t = $time;
          done_cnt++;
          check("sweep_busy_at_done", sweep_busy, 0);
          expect_ev(EV_DONE, 0, int'(fail_count), sweep_aborted);
        end
      end
      prev_start = dev_start;
    end
  end

  // Front-end model: answers dev_start with busy, a done pulse, then releases busy.
  initial begin
    int st = 0, cnt = 0;
    dev_busy = 1'b0; dev_done = 1'b0; sweep_abort = 1'b0;
    forever begin
      @(negedge clk);
      dev_done = 1'b0;
      if (dev_rst) begin
        st = 0; dev_busy = 1'b0; dev_rst = 1'b0;
      end else begin
        if (st == 0 && dev_start === 1'b1 && int'(dev_channel) != dead_ch) begin
          cnt = fixed_timing ? 1 : int'($urandom_range(0, 2));
          st  = 1;
        end
        if (st == 1) begin
          if (cnt == 0) begin
            dev_busy = 1'b1;
            if (int'(dev_channel) == abort_ch) begin cnt = 2; st = 5; end
            else begin cnt = fixed_timing ? 9 : int'($urandom_range(0, 4)); st = 2; end
          end else cnt--;
        end else if (st == 2) begin
          if (cnt == 0) begin
            dev_done = 1'b1;
            cnt = fixed_timing ? 0 : int'($urandom_range(0, 2));
            st  = 3;
          end else cnt--;
        end else if (st == 3) begin
          if (cnt == 0) begin dev_busy = 1'b0; st = 0; end else cnt--;
        end else if (st == 5) begin
          if (cnt == 0) begin sweep_abort = 1'b1; cnt = 6; st = 4; end else cnt--;
        end else if (st == 4) begin
          if (cnt == 0) begin dev_busy = 1'b0; busy_fall_t = $time; st = 0; end else cnt--;
        end
      end
    end
  end

  task automatic run_sweep(input int first, input int last, input bit mid_pulse);
    int n0 = done_cnt;
    bit got = 1'b0;
    build_expect(first, last);
    @(negedge clk);
    ch_first = CH_W'(first); ch_last = CH_W'(last);
    sweep_start = 1'b1; start_t = $time; issue_t = 0;
    @(negedge clk);
    sweep_start = 1'b0;
    check("sweep_busy_after_start", sweep_busy, 1);
    if (mid_pulse) begin
      repeat (5) @(negedge clk);
      ch_first = '0; ch_last = CH_W'(100); sweep_start = 1'b1;
      @(negedge clk);
      sweep_start = 1'b0;
    end
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = (done_cnt > n0);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL sweep_timeout: no sweep_done for sweep %0d..%0d", first, last);
    end
    sweep_abort = 1'b0;
    repeat (4) @(negedge clk);
    check("sweep_done_count", done_cnt, n0 + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    bit seen = 1'b0;
    rstn = 1'b0; sweep_start = 1'b0; ch_first = '0; ch_last = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {dev_start, dev_channel, sweep_busy, sweep_done, sweep_aborted,
                            ch_fail, fail_channel, fail_count}, 0);
    rstn = 1'b1;

    run_sweep(0, 4, 1'b0);
    check("dev_start_latency", longint'(issue_t - start_t), 10);
    fixed_timing = 1'b0;

    run_sweep(7, 3, 1'b0);
    check("empty_sweep_done_latency", longint'(done_t - start_t), 20);

    run_sweep(0, 2, 1'b1);

    abort_ch = 3; busy_fall_t = 0;
    run_sweep(0, 9, 1'b0);
    check("done_after_busy_fall", longint'(done_t > busy_fall_t), 1);
    abort_ch = -1;

`ifdef ZSWEEP_TIMEOUT_EN
    dead_ch = 2;
    run_sweep(0, 3, 1'b0);
    check("fail_channel_held", fail_channel, 2);
    dead_ch = -1;
`endif

    run_sweep(CH_MAX - 2, CH_MAX, 1'b0);

    for (int k = 0; k < 6; k++)
      run_sweep(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 1'b0);

    fixed_timing = 1'b1;
    build_expect(0, 9);
    @(negedge clk);
    ch_first = '0; ch_last = CH_W'(9); sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = dev_busy && (dev_channel == CH_W'(1));
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL reach_wait: channel 1 never became busy");
    end
    repeat (2) @(negedge clk);
    dev_rst = 1'b1; rstn = 1'b0;
    @(negedge clk);
    check("mid_sweep_reset_outputs", {dev_start, dev_channel, sweep_busy, sweep_done, sweep_aborted,
                                      ch_fail, fail_channel, fail_count}, 0);
    rstn = 1'b1;
    exp_q.delete();
    fixed_timing = 1'b0;
    run_sweep(0, 1, 1'b0);

    check("events_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
